stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control sequencer for the stopwatch datapath. It debounces the raw start/stop, clear and lap slide switches and runs the IDLE/RUN/PAUSE state machine. It also generates the gated centisecond tick that advances the centiseconds/seconds/minutes/hours counters, and issues the clear and lap-capture strobes. It sits between the board switches and the time counters inside `stopwatch_top`, replacing ad-hoc `running` logic.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles before a switch level is accepted (10 ms at 100 MHz).
- `TICK_CYCLES`, default 1_000_000: clock cycles per `tick` in RUN (100 Hz).
- `CLK100MHZ` in 1: system clock. Only clock.
- `CPU_RESETN` in 1: reset, synchronous, active-low.
- `sw_start` in 1: raw SW[0]. Asynchronous to the clock. A rising edge toggles run/pause.
- `sw_clear` in 1: raw SW[1]. A rising edge returns to IDLE.
- `sw_lap` in 1: raw SW[2]. A rising edge toggles the lap hold.
- `tick` out 1: one-cycle pulse that advances the counters by 1 cs.
- `clear` out 1: one-cycle pulse that zeroes the counters and the lap register.
- `running` out 1: high in RUN.
- `lap_load` out 1: one-cycle pulse that latches the counters into the lap register.
- `lap_hold` out 1: display shows the lap register instead of the live count.
- `state` out 2: current FSM state, for debug.

## Operation
- Each switch passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level takes the synchronized value only after that value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A rising edge of the debounced level produces a one-cycle event: `ev_start`, `ev_clear` or `ev_lap`.
  - Falling edges produce no event.
- FSM, encoded IDLE=0, RUN=1, PAUSE=2. Code 3 is illegal and recovers to IDLE with a `clear` pulse.
  - IDLE: `ev_start` goes to RUN. The prescaler starts from 0.
  - RUN: `ev_start` goes to PAUSE. `ev_clear` goes to IDLE.
  - PAUSE: `ev_start` goes to RUN, and the prescaler resumes from its held value (no lost or extra fraction). `ev_clear` goes to IDLE.
  - IDLE with `ev_clear`: stays IDLE and still pulses `clear`.
  - `ev_clear` and `ev_start` in the same cycle: clear wins, result is IDLE.
- Prescaler, width $clog2(TICK_CYCLES):
  - Increments every cycle in RUN.
  - When it equals TICK_CYCLES-1, `tick`=1 and it wraps to 0.
  - Held in PAUSE. Zeroed in IDLE.
- Lap behaviour:
  - `ev_lap` in RUN with `lap_hold`=0 sets `lap_hold` and pulses `lap_load`.
  - `ev_lap` in RUN with `lap_hold`=1 clears `lap_hold`.
  - `ev_lap` in PAUSE only clears `lap_hold`. `ev_lap` in IDLE is ignored.
  - `ev_lap` together with a prescaler wrap: both `tick` and `lap_load` fire. The lap register latches the pre-tick value.
  - Entering IDLE forces `lap_hold`=0.
- A switch held high through reset: its debounced level resets to 0, so it yields one event DEBOUNCE_CYCLES+2 cycles after reset release.

## Timing
- All outputs are registered.
- Reset values:
  - `state`=IDLE; `running`, `tick`, `clear`, `lap_load`, `lap_hold` all 0.
  - Prescaler 0. Debounced levels 0. Synchronizer and edge flops 0.
- Latency from a raw switch edge (first sampling cycle C) to its event: the event is high in cycle C+2+DEBOUNCE_CYCLES.
- The new `state`, `running`, `clear`, `lap_load` and `lap_hold` values appear one cycle after the event.
- First `tick` after entering RUN from IDLE: TICK_CYCLES cycles after `running` rises. Subsequent ticks are exactly TICK_CYCLES apart while in RUN.
- `clear` and `tick` are never high in the same cycle.
- No `tick` is issued in the cycle RUN is left.
- Reset mid-operation: every register returns to its reset value on the next clock edge with `CPU_RESETN`=0, regardless of pending events.

## Structure
- `stopwatch_pkg` holds:
  - the state encoding (`ST_IDLE`, `ST_RUN`, `ST_PAUSE`);
  - the default DEBOUNCE/TICK constants for 100 MHz;
  - a reduced simulation constant set (DEBOUNCE=4, TICK=10).
- One sub-module, `sw_debounce`: synchronizer, stability counter, debounced level and rising-edge pulse. It is parameterized by DEBOUNCE_CYCLES and instantiated three times.
- The FSM, prescaler and lap logic live in `stopwatch_ctrl`.

## Test plan
Run with DEBOUNCE_CYCLES=4, TICK_CYCLES=10.
- Reset, then raise `sw_start` and hold it → `running`=1 exactly 7 cycles after first sampling; first `tick` 10 cycles later; ticks every 10 cycles.
- In RUN, pulse `sw_start` → PAUSE with the prescaler held at value k; pulse again → the next `tick` arrives 10-k cycles after `running` re-rises.
- `sw_start` that bounces 0/1 every 2 cycles for 20 cycles, then is stable high → exactly one `ev_start`, one state change.
- In RUN with lap_hold=0, pulse `sw_lap` → `lap_load` one cycle, `lap_hold`=1, ticks continue; pulse again → `lap_hold`=0, no `lap_load`.
- `sw_start` and `sw_clear` raised in the same cycle while in RUN → IDLE, one `clear` pulse, no tick afterwards, `lap_hold`=0.
- Assert `CPU_RESETN`=0 for one cycle mid-RUN with a debounce in progress → all outputs 0 and IDLE next cycle; no stale event after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
// Holds the FSM state encoding plus board and simulation timing constants.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // 100 MHz board: 10 ms debounce, 100 Hz centisecond tick
    localparam int DEBOUNCE_100MHZ = 1_000_000;
    localparam int TICK_100MHZ     = 1_000_000;

    // Reduced set for simulation
    localparam int DEBOUNCE_SIM = 4;
    localparam int TICK_SIM     = 10;

endpackage

// File: rtl/sw_debounce.sv
// One slide switch: 2-flop synchronizer, stability counter, debounced level
// and a registered one-cycle pulse on each debounced rising edge.
// Ports: clk, rst_n (sync, active-low), raw (async switch), rise (event).
module sw_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            prev  <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any sample matching the current level restarts the count
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            prev <= level;
            rise <= level & ~prev;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced switch events, IDLE/RUN/PAUSE FSM,
// gated centisecond prescaler, clear and lap-capture strobes.
// Ports: CLK100MHZ, CPU_RESETN (sync, active-low), sw_start/sw_clear/sw_lap
// (raw switches); tick, clear, running, lap_load, lap_hold, state (registered).
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ,
    parameter int TICK_CYCLES     = TICK_100MHZ
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       sw_start,
    input  logic       sw_clear,
    input  logic       sw_lap,
    output logic       tick,
    output logic       clear,
    output logic       running,
    output logic       lap_load,
    output logic       lap_hold,
    output logic [1:0] state
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);

    logic ev_start;
    logic ev_clear;
    logic ev_lap;

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .raw   (sw_start),
        .rise  (ev_start)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .raw   (sw_clear),
        .rise  (ev_clear)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .raw   (sw_lap),
        .rise  (ev_lap)
    );

    state_t        cur;
    state_t        nxt;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_n;
    logic          tick_n;
    logic          clear_n;
    logic          load_n;
    logic          hold_n;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            cur      <= ST_IDLE;
            pre      <= '0;
            tick     <= 1'b0;
            clear    <= 1'b0;
            running  <= 1'b0;
            lap_load <= 1'b0;
            lap_hold <= 1'b0;
        end else begin
            cur      <= nxt;
            pre      <= pre_n;
            tick     <= tick_n;
            clear    <= clear_n;
            running  <= (nxt == ST_RUN);
            lap_load <= load_n;
            lap_hold <= hold_n;
        end
    end

    always_comb begin
        nxt     = cur;
        pre_n   = pre;
        tick_n  = 1'b0;
        clear_n = 1'b0;
        load_n  = 1'b0;
        hold_n  = lap_hold;
        case (cur)
            ST_IDLE: begin
                pre_n  = '0;
                hold_n = 1'b0;
                if (ev_clear) begin
                    clear_n = 1'b1;
                end else if (ev_start) begin
                    nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ev_clear) begin
                    nxt     = ST_IDLE;
                    clear_n = 1'b1;
                    pre_n   = '0;
                    hold_n  = 1'b0;
                end else begin
                    if (ev_lap) begin
                        load_n = ~lap_hold;
                        hold_n = ~lap_hold;
                    end
                    // Leaving RUN freezes the fraction so resume is exact
                    if (ev_start) begin
                        nxt = ST_PAUSE;
                    end else if (pre == PRE_MAX) begin
                        tick_n = 1'b1;
                        pre_n  = '0;
                    end else begin
                        pre_n = pre + PW'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (ev_clear) begin
                    nxt     = ST_IDLE;
                    clear_n = 1'b1;
                    pre_n   = '0;
                    hold_n  = 1'b0;
                end else begin
                    if (ev_lap) begin
                        hold_n = 1'b0;
                    end
                    if (ev_start) begin
                        nxt = ST_RUN;
                    end
                end
            end
            default: begin
                nxt     = ST_IDLE;
                clear_n = 1'b1;
                pre_n   = '0;
                hold_n  = 1'b0;
            end
        endcase
    end

    assign state = cur;

endmodule
